// File: rtl/ysyx_22050612_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// State encodings: IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2; owner: 0 = IFU, 1 = LSU.
package ysyx_22050612_mem_arbiter_pkg;

  // Register width of the core; the arbiter's default data width.
  localparam int RGSIZE = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Width of the watchdog counter: enough to hold TIMEOUT, never below 1 bit.
  function automatic int cnt_width(input int unsigned t);
    int w;
    w = $clog2(t + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/ysyx_22050612_rr_pick.sv
// Two-way round-robin picker. Purely combinational; the caller owns last_grant.
// grant[0] = IFU, grant[1] = LSU. A lone requester always wins; on a tie the
// requester opposite last_grant wins.
module ysyx_22050612_rr_pick
  import ysyx_22050612_mem_arbiter_pkg::*;
(
  input  logic       req_ifu,
  input  logic       req_lsu,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  // One-hot (or zero) grant from the two request lines and the previous winner.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req_ifu & (~req_lsu | (last_grant == OWN_LSU));
    grant[1] = req_lsu & (~req_ifu | (last_grant == OWN_IFU));
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Single-outstanding memory arbiter between IFU (read-only) and LSU.
// IDLE picks a requester round-robin and registers its payload, REQ presents
// it to memory until accepted, WAIT routes the response (or a watchdog
// timeout) back to the owner.
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = RGSIZE,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err_stray_rsp
);

  localparam int CW = cnt_width(TIMEOUT);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic            stray_q, stray_d;

  logic [1:0]      grant;
  logic            timeout_hit;
  logic            rsp_fire;
  logic [DW-1:0]   rsp_data;

  ysyx_22050612_rr_pick u_pick (
    .req_ifu    (ifu_req_valid),
    .req_lsu    (lsu_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign err_stray_rsp = stray_q;

  // Next-state, payload capture, response routing; every output gated by rst.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    stray_d       = stray_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    rsp_fire      = 1'b0;
    rsp_data      = '0;
    rsp_err       = 1'b0;
    // A watchdog of 0 never fires.
    timeout_hit   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    // A response with no transaction waiting for it is flagged and dropped.
    if (mem_rsp_valid && (state_q != ST_WAIT)) stray_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        ifu_req_ready = grant[0];
        lsu_req_ready = grant[1];
        if (grant[0]) begin
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          state_d      = ST_REQ;
        end else if (grant[1]) begin
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A real response beats a coincident timeout.
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = mem_rdata;
          state_d  = ST_IDLE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          if (timeout_hit) begin
            rsp_fire = 1'b1;
            rsp_err  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
    lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
    ifu_rdata     = ifu_rsp_valid ? rsp_data : '0;
    lsu_rdata     = lsu_rsp_valid ? rsp_data : '0;

    if (rst) begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      ifu_rdata     = '0;
      lsu_rdata     = '0;
      rsp_err       = 1'b0;
    end
  end

  // State and payload registers; LSU as last_grant lets IFU win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      stray_q      <= stray_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: a table of directed
// transactions, hand-written reset/stray sequences, then random transactions
// checked against a transaction-level round-robin model.
module tb_ysyx_22050612_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        rsp_err, mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        err_stray_rsp;

  int checks = 0;
  int errors = 0;
  bit model_last;  // owner of the most recent grant: 0 = IFU, 1 = LSU

  typedef struct {
    bit          iv, lv, wen;
    logic [63:0] ia, la, wd;
    logic [7:0]  wm;
    int          rdly, sdly;
    logic [63:0] rd;
    bit          own, err;
  } vec_t;

  vec_t tbl[8];

  ysyx_22050612_mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .rsp_err(rsp_err), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .err_stray_rsp(err_stray_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit iv, bit lv, bit wen, logic [63:0] ia, logic [63:0] la,
                              logic [63:0] wd, logic [7:0] wm, int rdly, int sdly,
                              logic [63:0] rd, bit own, bit err);
    vec_t v;
    v.iv = iv; v.lv = lv; v.wen = wen; v.ia = ia; v.la = la; v.wd = wd; v.wm = wm;
    v.rdly = rdly; v.sdly = sdly; v.rd = rd; v.own = own; v.err = err;
    return v;
  endfunction

  // One full transaction: handshake, rdly cycles of mem_req_ready low, then a
  // response sdly cycles into WAIT (or a timeout TO cycles in if sdly > TO).
  task automatic do_txn(input vec_t v);
    logic [63:0] ea, ed, exp_rd;
    logic        ew;
    logic [7:0]  em;
    int          last;
    bit          fire;
    @(negedge clk);
    ifu_req_valid = v.iv;  ifu_addr  = v.ia;
    lsu_req_valid = v.lv;  lsu_addr  = v.la;  lsu_wen = v.wen;
    lsu_wdata     = v.wd;  lsu_wmask = v.wm;
    mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;
    #1;
    chk("ifu_req_ready", ifu_req_ready, v.own == 1'b0);
    chk("lsu_req_ready", lsu_req_ready, v.own == 1'b1);
    model_last = v.own;
    if (v.own) begin ea = v.la; ew = v.wen; ed = v.wd; em = v.wm; end
    else       begin ea = v.ia; ew = 1'b0;  ed = '0;   em = 8'h00; end
    for (int k = 0; k <= v.rdly; k++) begin
      @(negedge clk);
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      mem_req_ready = (k == v.rdly);
      #1;
      chk("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wen", mem_wen, ew);
      chk("mem_wmask", mem_wmask, em);
      if (v.own) chk("mem_wdata", mem_wdata, ed);
      chk("req_ready_in_req", {ifu_req_ready, lsu_req_ready}, 2'b00);
    end
    last = (v.sdly <= TO) ? v.sdly : TO;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = (k == v.sdly);
      mem_rdata     = (k == v.sdly) ? v.rd : {$urandom, $urandom};
      #1;
      fire   = (k == last);
      exp_rd = (fire && !v.err) ? v.rd : 64'h0;
      chk("ifu_rsp_valid", ifu_rsp_valid, fire && !v.own);
      chk("lsu_rsp_valid", lsu_rsp_valid, fire && v.own);
      chk("rsp_err", rsp_err, fire && v.err);
      chk("ifu_rdata", ifu_rdata, (fire && !v.own) ? exp_rd : 64'h0);
      chk("lsu_rdata", lsu_rdata, (fire && v.own) ? exp_rd : 64'h0);
      chk("mem_req_valid_wait", mem_req_valid, 1'b0);
    end
    $display("txn owner=%0d addr=%h wen=%0b rdly=%0d sdly=%0d err=%0b",
             v.own, ea, ew, v.rdly, v.sdly, v.err);
  endtask

  initial begin
    vec_t v;
    int   p;

    tbl[0] = mk(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 0, 0, 64'h13, 0, 0);
    tbl[1] = mk(1, 1, 1, 64'h8000_0004, 64'h8000_1000, 64'hdead_beef, 8'h0f, 0, 0, 64'h0, 1, 0);
    tbl[2] = mk(1, 1, 0, 64'h8000_0008, 64'h8000_2000, 64'h0, 8'hff, 0, 1, 64'h1111_2222_3333_4444, 0, 0);
    tbl[3] = mk(1, 1, 0, 64'h8000_000c, 64'h8000_3000, 64'h0, 8'hff, 0, 2, 64'hcafe_f00d_0000_0001, 1, 0);
    tbl[4] = mk(0, 1, 1, 64'h0, 64'h8000_4000, 64'h0123_4567_89ab_cdef, 8'hf0, 5, 0, 64'h0, 1, 0);
    tbl[5] = mk(1, 0, 0, 64'h8000_0010, 64'h0, 64'h0, 8'h00, 0, 20, 64'hffff_ffff_ffff_ffff, 0, 1);
    tbl[6] = mk(1, 1, 0, 64'h8000_0014, 64'h8000_5000, 64'h0, 8'hff, 1, TO, 64'h5555_aaaa_5555_aaaa, 1, 0);
    tbl[7] = mk(0, 1, 0, 64'h0, 64'h8000_6000, 64'h0, 8'hff, 0, TO + 1, 64'h77, 1, 1);

    // Reset: requests present but nothing may be granted while rst is high.
    rst = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 64'h0; lsu_addr = 64'h0; lsu_wen = 1'b0; lsu_wdata = 64'h0; lsu_wmask = 8'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ifu_req_ready", ifu_req_ready, 1'b0);
    chk("rst_lsu_req_ready", lsu_req_ready, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wmask", mem_wmask, 8'h00);
    chk("rst_err_stray", err_stray_rsp, 1'b0);
    @(negedge clk);
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    model_last = 1'b1;

    for (int i = 0; i < 8; i++) do_txn(tbl[i]);

    // Stray response in IDLE: no pulse, sticky flag, cleared only by rst.
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
    #1;
    chk("stray_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("stray_lsu_rsp", lsu_rsp_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("stray_flag_set", err_stray_rsp, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("stray_flag_sticky", err_stray_rsp, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stray_flag_cleared", err_stray_rsp, 1'b0);
    model_last = 1'b1;

    // Reset while waiting on an IFU read: abandoned, no pulse, IFU wins next tie.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0200;
    #1;
    chk("midrst_ifu_ready", ifu_req_ready, 1'b1);
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    chk("midrst_mem_req_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req_valid_low", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h99;
    #1;
    chk("midrst_no_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("midrst_no_lsu_rsp", lsu_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    chk("midrst_no_stray", err_stray_rsp, 1'b0);
    model_last = 1'b1;
    do_txn(mk(1, 1, 1, 64'h8000_0300, 64'h8000_7000, 64'h42, 8'h01, 0, 0, 64'hab, 0, 0));

    // Random transactions against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      p       = $urandom_range(1, 3);
      v.iv    = p[0];
      v.lv    = p[1];
      v.wen   = $urandom_range(0, 1) != 0;
      v.ia    = {$urandom, $urandom};
      v.la    = {$urandom, $urandom};
      v.wd    = {$urandom, $urandom};
      v.wm    = 8'($urandom);
      v.rdly  = $urandom_range(0, 3);
      v.sdly  = $urandom_range(0, TO + 2);
      v.rd    = {$urandom, $urandom};
      if (v.iv && !v.lv)      v.own = 1'b0;
      else if (v.lv && !v.iv) v.own = 1'b1;
      else                    v.own = !model_last;
      v.err   = (v.sdly > TO);
      do_txn(v);
    end

    @(negedge clk);
    mem_rsp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Shares the single memory port between IFU (instruction fetch, read-only) and LSU (load/store).
- One outstanding transaction at a time, with a 2-way round-robin grant.
- Transaction FSM with response routing and a response timeout watchdog.
- Sits between IFU/EXU-LSU and the memory model/bus of the npc top, replacing direct IFU-to-memory wiring.

Parameters:
- AW, 64, address width
- DW, 64, data width (matches `ysyx_22050612_rgsize)
- TIMEOUT, 1023, max cycles waiting for mem_rsp_valid; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_rsp_valid  out  1  one-cycle pulse, ifu_rdata valid
- ifu_rdata  out  DW  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  access address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  byte write mask
- lsu_rsp_valid  out  1  one-cycle pulse, lsu_rdata valid (also pulses for stores)
- lsu_rdata  out  DW  load data
- rsp_err  out  1  pulses with x_rsp_valid when the response was produced by timeout
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  registered address
- mem_wen  out  1  registered write enable (0 for IFU)
- mem_wdata  out  DW  registered store data
- mem_wmask  out  DW/8  registered mask (0 for IFU)
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data
- err_stray_rsp  out  1  sticky: mem_rsp_valid seen outside WAIT; cleared only by rst

Behaviour:
- States: IDLE, REQ, WAIT. Register owner (0 = IFU, 1 = LSU) and last_grant.
- Reset: state = IDLE, last_grant = LSU (so IFU wins the first tie), err_stray_rsp = 0, timeout counter = 0, mem_* payload registers = 0. All valid/ready outputs are 0 while rst is high. Combinational outputs are gated by rst.
- IDLE:
  - Exactly one of ifu_req_ready/lsu_req_ready may be 1, and only if the corresponding requester is valid.
  - Winner: the only valid requester, or on a tie the requester opposite last_grant.
  - On handshake: capture addr/wen/wdata/wmask (IFU forces wen = 0, wmask = 0), set owner, update last_grant, go to REQ.
- REQ:
  - mem_req_valid = 1 with the registered payload, held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT and clear the counter.
  - Both req_ready outputs are 0.
- WAIT:
  - On mem_rsp_valid: owner's x_rsp_valid = 1 the same cycle, x_rdata = mem_rdata (combinational path), go to IDLE.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT: owner's x_rsp_valid = 1, x_rdata = 0, rsp_err = 1, go to IDLE.
- Non-owner rsp_valid is always 0. rdata outputs are 0 when not valid.
- Minimum latency:
  - Request handshake at cycle T, mem_req_valid at T+1.
  - If mem_req_ready at T+1, the earliest response is at T+2.
  - Next accept is at T+3.
- mem_rsp_valid in IDLE/REQ is ignored and sets err_stray_rsp.
- A response and a timeout in the same cycle: the response wins, rsp_err = 0.
- A requester dropping valid before its handshake is legal. A requester must hold its payload until ready.
- Reset mid-transaction: the transaction is abandoned, no rsp pulse, and mem_req_valid is 0 from the cycle rst is high. The memory side is also reset by the same rst.
- Timeout counter width: clog2(TIMEOUT+1), saturating; it never wraps.

Decomposition:
- Shared header ysyx_22050612_defines.vh: state encodings (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2), the owner encoding, `ysyx_22050612_rgsize.
- One sub-module, ysyx_22050612_rr_pick: 2-way round-robin picker (inputs: two valids, last_grant; outputs: grant vector). Purely combinational; last_grant stays in the arbiter.

Test Plan:
- Reset, then IFU req addr 0x80000000; mem_req_ready = 1 immediately, rsp 1 cycle later with rdata 0x00000013 -> ifu_req_ready at T, mem_req_valid with addr 0x80000000 and wen = 0 at T+1, ifu_rsp_valid and rdata 0x13 at T+2, lsu_rsp_valid never asserted.
- IFU and LSU both valid continuously for 4 transactions -> grants IFU, LSU, IFU, LSU; LSU store addr 0x80001000, wdata 0xdeadbeef, wmask 0x0f appears unchanged on mem_*.
- mem_req_ready held low 5 cycles -> mem_req_valid and payload stable for all 5 cycles, no ready to either requester.
- TIMEOUT = 8, no mem_rsp_valid -> owner rsp_valid and rsp_err exactly 8 cycles after entering WAIT, rdata = 0, FSM returns to IDLE.
- mem_rsp_valid pulsed in IDLE -> err_stray_rsp = 1 and stays 1, no rsp pulse; cleared by rst.
- rst asserted during WAIT, then response arrives -> no rsp pulse; after reset release the first tie grants IFU.
